hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Central stall/forward controller for the 5-stage MIPS pipeline (F, D, E, M, W). It consumes the E-stage write descriptor (`Tnew_E`, `Num_new_E`) from the E-stage hazard decoder and the D-stage instruction. It keeps registered copies of the in-flight write descriptors and source operands for E, M and W, and issues the pipeline stall plus the forwarding-mux selects for D, E and M.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all internal stage copies.
- `Instr_D`  in  32  instruction currently in the D stage.
- `Tnew_E`  in  2  cycles until the E-stage instruction's result exists (0..2).
- `Num_new_E`  in  5  destination register of the E-stage instruction; 0 means no write.
- `stall`  out  1  freeze PC and F/D register, insert bubble into D/E register.
- `Fwd_rs_D`, `Fwd_rt_D`  out  2 each  D operand select: 00 RF, 01 E, 10 M, 11 W.
- `Fwd_rs_E`, `Fwd_rt_E`  out  2 each  E operand select: 00 D/E register, 01 M, 10 W.
- `Fwd_rt_M`  out  1  M store-data select: 0 E/M register, 1 W.

## Operation
- **Tuse decode of `Instr_D`, with 3 meaning unused:**
  - beq: rs=0, rt=0.
  - jr and bltzal (opcode 6'b111111): rs=0, rt=3.
  - add/sub: rs=1, rt=1.
  - ori/lw: rs=1, rt=3.
  - sw: rs=1, rt=2.
  - lui, j, jal, unknown opcode/funct: rs=3, rt=3.
- **Internal stage state:**
  - E stage: `rs_E`, `rt_E` (5 bits each).
  - M stage: `Tnew_M` (2), `Num_M` (5), `rt_M` (5).
  - W stage: `Num_W` (5).
  - W-stage Tnew is always 0.
- **Per clock edge, when `reset` = 0:**
  - `rs_E`/`rt_E` <= `Instr_D[25:21]`/`Instr_D[20:16]` if `stall` = 0. Otherwise they are set to 0, which is a bubble.
  - `Tnew_M` <= (`Tnew_E` == 0) ? 0 : `Tnew_E` − 1, saturating at 0.
  - `Num_M` <= `Num_new_E`; `rt_M` <= `rt_E`.
  - `Num_W` <= `Num_M`.
  - M and W always advance; stall never freezes them.
- **Stall:** asserted when, for operand X in {rs, rt} of `Instr_D` with X ≠ 0, either of these holds:
  - X == `Num_new_E` and Tuse_X < `Tnew_E`.
  - X == `Num_M` and Tuse_X < `Tnew_M`.
  - Tuse 3 never stalls.
- **Forward selects:** a source stage qualifies only if its Num ≠ 0, its Num equals the operand, and its Tnew == 0.
  - D selects check E, then M, then W; the first match wins.
  - E selects check M, then W.
  - `Fwd_rt_M` = 1 iff `rt_M` ≠ 0 and `rt_M` == `Num_W`.
  - No match gives 0.
- **Register $0:** never forwarded and never causes a stall, regardless of `Num_new_E`.
- **Treated as plain data:**
  - `Num_new_E` = 31 with `Tnew_E` = 0 (jal, bltzal link) forwards like any write.
  - A bubble in E appears as `Num_new_E` = 0 and needs no special case.

## Timing
- **Reset:** all internal registers become 0. As a result, `stall` = 0 and every forward select = 0 in the cycle after reset, provided `Instr_D` references nothing in flight.
- **Combinational outputs:** `stall` and all forward selects depend on current state and current inputs only, with zero-cycle latency.
- **Effect of a stall:**
  - A stalled cycle puts a bubble into E at the next edge.
  - The upstream decoder then presents `Num_new_E` = 0 and `Tnew_E` = 0.
  - Stalls last exactly max(Tnew − Tuse) cycles. Example: lw→beq on the same register stalls 2 cycles; lw→add stalls 1.
- **Reset mid-stall:** `reset` dominates. On that edge all stage copies clear, so no stall carries over.
- **Simultaneous matches:** when the same register matches in E, M and W, the youngest stage (E) wins, and it must also satisfy Tnew == 0.

## Test plan
- Reset with `Instr_D` = add $3,$1,$2 and nothing in flight → `stall` = 0, all selects 00 / 0 for every cycle.
- E has lw → $5 (`Tnew_E` = 2, `Num_new_E` = 5), D = beq $5,$0:
  - `stall` = 1 for 2 cycles.
  - Third cycle: `stall` = 0 and `Fwd_rs_D` = 11 (W).
- E has ori → $7 (`Tnew_E` = 1), D = add $8,$7,$7:
  - `stall` = 0 in the first cycle.
  - Next cycle: `Fwd_rs_E` = `Fwd_rt_E` = 01 (M).
- E has jal (`Tnew_E` = 0, `Num_new_E` = 31), D = jr $31 → `stall` = 0, `Fwd_rs_D` = 01 (E).
- E has lw → $4 and D = sw $4,0($9) (rt Tuse 2):
  - `stall` = 0.
  - Two cycles later, with sw in M and lw in W: `Fwd_rt_M` = 1.
- E has lw → $0 and D = add $1,$0,$0 → `stall` = 0, all selects 0. Assert `reset` during an lw→beq stall → next cycle `stall` = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
//==============================================================================
//  Module      : hazard_ctrl
//  Description : Central stall / forward controller for a 5-stage MIPS
//                pipeline (F, D, E, M, W). Tracks the write descriptors and
//                source registers of the instructions in E, M and W. From
//                that state it produces the pipeline stall and the
//                forwarding-mux selects for the D, E and M stages.
//
//  Ports
//    clk        in   1   pipeline clock, rising edge
//    reset      in   1   synchronous active-high, clears all stage copies
//    Instr_D    in  32   instruction currently in D
//    Tnew_E     in   2   cycles until the E-stage result exists (0..2)
//    Num_new_E  in   5   destination register of the E instruction (0 = none)
//    stall      out  1   freeze PC and F/D, bubble into D/E
//    Fwd_rs_D   out  2   D rs select: 00 RF, 01 E, 10 M, 11 W
//    Fwd_rt_D   out  2   D rt select: 00 RF, 01 E, 10 M, 11 W
//    Fwd_rs_E   out  2   E rs select: 00 D/E reg, 01 M, 10 W
//    Fwd_rt_E   out  2   E rt select: 00 D/E reg, 01 M, 10 W
//    Fwd_rt_M   out  1   M store-data select: 0 E/M reg, 1 W
//
//  Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_D,
    input  logic [1:0]  Tnew_E,
    input  logic [4:0]  Num_new_E,
    output logic        stall,
    output logic [1:0]  Fwd_rs_D,
    output logic [1:0]  Fwd_rt_D,
    output logic [1:0]  Fwd_rs_E,
    output logic [1:0]  Fwd_rt_E,
    output logic        Fwd_rt_M
);

    //--------------------------------------------------------------------------
    // Opcode / funct encodings used by the Tuse decoder
    //--------------------------------------------------------------------------
    localparam logic [5:0] c_OP_RTYPE  = 6'b000000;
    localparam logic [5:0] c_OP_BEQ    = 6'b000100;
    localparam logic [5:0] c_OP_BLTZAL = 6'b111111;
    localparam logic [5:0] c_OP_ORI    = 6'b001101;
    localparam logic [5:0] c_OP_LW     = 6'b100011;
    localparam logic [5:0] c_OP_SW     = 6'b101011;

    localparam logic [5:0] c_FN_ADD    = 6'b100000;
    localparam logic [5:0] c_FN_SUB    = 6'b100010;
    localparam logic [5:0] c_FN_JR     = 6'b001000;

    // Tuse value meaning "operand not read"; it is larger than any legal
    // Tnew, so it can never satisfy Tuse < Tnew.
    localparam logic [1:0] c_TUSE_NONE = 2'd3;

    //--------------------------------------------------------------------------
    // D-stage field extraction
    //--------------------------------------------------------------------------
    logic [5:0] w_op_D;
    logic [5:0] w_fn_D;
    logic [4:0] w_rs_D;
    logic [4:0] w_rt_D;

    assign w_op_D = Instr_D[31:26];
    assign w_fn_D = Instr_D[5:0];
    assign w_rs_D = Instr_D[25:21];
    assign w_rt_D = Instr_D[20:16];

    //--------------------------------------------------------------------------
    // Tuse decode: the number of cycles after D at which each operand is
    // first consumed (0 = in D, 1 = in E, 2 = in M, 3 = never).
    //--------------------------------------------------------------------------
    logic [1:0] w_tuse_rs;
    logic [1:0] w_tuse_rt;

    always_comb begin
        w_tuse_rs = c_TUSE_NONE;
        w_tuse_rt = c_TUSE_NONE;
        case (w_op_D)
            c_OP_BEQ: begin
                w_tuse_rs = 2'd0;
                w_tuse_rt = 2'd0;
            end
            c_OP_BLTZAL: begin
                w_tuse_rs = 2'd0;
            end
            c_OP_ORI, c_OP_LW: begin
                w_tuse_rs = 2'd1;
            end
            c_OP_SW: begin
                // Base address is needed by the ALU, store data only in M.
                w_tuse_rs = 2'd1;
                w_tuse_rt = 2'd2;
            end
            c_OP_RTYPE: begin
                case (w_fn_D)
                    c_FN_ADD, c_FN_SUB: begin
                        w_tuse_rs = 2'd1;
                        w_tuse_rt = 2'd1;
                    end
                    c_FN_JR: begin
                        w_tuse_rs = 2'd0;
                    end
                    default: begin
                        w_tuse_rs = c_TUSE_NONE;
                        w_tuse_rt = c_TUSE_NONE;
                    end
                endcase
            end
            default: begin
                // lui, j, jal and anything unrecognised read no registers.
                w_tuse_rs = c_TUSE_NONE;
                w_tuse_rt = c_TUSE_NONE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Stage copies
    //--------------------------------------------------------------------------
    logic [4:0] r_rs_E;
    logic [4:0] r_rt_E;
    logic [1:0] r_tnew_M;
    logic [4:0] r_num_M;
    logic [4:0] r_rt_M;
    logic [4:0] r_num_W;

    // One cycle of progress for the E-stage producer, floored at zero.
    logic [1:0] w_tnew_M_next;
    assign w_tnew_M_next = (Tnew_E == 2'd0) ? 2'd0 : (Tnew_E - 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs_E   <= 5'd0;
            r_rt_E   <= 5'd0;
            r_tnew_M <= 2'd0;
            r_num_M  <= 5'd0;
            r_rt_M   <= 5'd0;
            r_num_W  <= 5'd0;
        end else begin
            // A stalled D instruction stays in D; E receives a bubble whose
            // sources are $0 so it can never request a forward.
            if (stall) begin
                r_rs_E <= 5'd0;
                r_rt_E <= 5'd0;
            end else begin
                r_rs_E <= w_rs_D;
                r_rt_E <= w_rt_D;
            end
            // M and W advance unconditionally; the stall only holds F and D.
            r_tnew_M <= w_tnew_M_next;
            r_num_M  <= Num_new_E;
            r_rt_M   <= r_rt_E;
            r_num_W  <= r_num_M;
        end
    end

    //--------------------------------------------------------------------------
    // Stall detection
    // An operand stalls when its producer in E or M will not have the value
    // ready by the time the consumer needs it (Tuse < Tnew). $0 is exempt.
    //--------------------------------------------------------------------------
    logic w_stall_rs;
    logic w_stall_rt;

    always_comb begin
        w_stall_rs = 1'b0;
        w_stall_rt = 1'b0;
        if (w_rs_D != 5'd0) begin
            if ((w_rs_D == Num_new_E) && (w_tuse_rs < Tnew_E)) begin
                w_stall_rs = 1'b1;
            end
            if ((w_rs_D == r_num_M) && (w_tuse_rs < r_tnew_M)) begin
                w_stall_rs = 1'b1;
            end
        end
        if (w_rt_D != 5'd0) begin
            if ((w_rt_D == Num_new_E) && (w_tuse_rt < Tnew_E)) begin
                w_stall_rt = 1'b1;
            end
            if ((w_rt_D == r_num_M) && (w_tuse_rt < r_tnew_M)) begin
                w_stall_rt = 1'b1;
            end
        end
    end

    assign stall = w_stall_rs | w_stall_rt;

    //--------------------------------------------------------------------------
    // Producer qualification
    // A stage can supply a value only when it writes a non-zero register and
    // its result already exists. W always holds a finished result.
    //--------------------------------------------------------------------------
    logic w_e_ready;
    logic w_m_ready;
    logic w_w_ready;

    assign w_e_ready = (Num_new_E != 5'd0) && (Tnew_E == 2'd0);
    assign w_m_ready = (r_num_M   != 5'd0) && (r_tnew_M == 2'd0);
    assign w_w_ready = (r_num_W   != 5'd0);

    //--------------------------------------------------------------------------
    // D-stage forwarding: youngest qualified producer wins (E, M, W)
    //--------------------------------------------------------------------------
    always_comb begin
        Fwd_rs_D = 2'b00;
        if (w_e_ready && (w_rs_D == Num_new_E)) begin
            Fwd_rs_D = 2'b01;
        end else if (w_m_ready && (w_rs_D == r_num_M)) begin
            Fwd_rs_D = 2'b10;
        end else if (w_w_ready && (w_rs_D == r_num_W)) begin
            Fwd_rs_D = 2'b11;
        end
    end

    always_comb begin
        Fwd_rt_D = 2'b00;
        if (w_e_ready && (w_rt_D == Num_new_E)) begin
            Fwd_rt_D = 2'b01;
        end else if (w_m_ready && (w_rt_D == r_num_M)) begin
            Fwd_rt_D = 2'b10;
        end else if (w_w_ready && (w_rt_D == r_num_W)) begin
            Fwd_rt_D = 2'b11;
        end
    end

    //--------------------------------------------------------------------------
    // E-stage forwarding: M before W
    //--------------------------------------------------------------------------
    always_comb begin
        Fwd_rs_E = 2'b00;
        if (w_m_ready && (r_rs_E == r_num_M)) begin
            Fwd_rs_E = 2'b01;
        end else if (w_w_ready && (r_rs_E == r_num_W)) begin
            Fwd_rs_E = 2'b10;
        end
    end

    always_comb begin
        Fwd_rt_E = 2'b00;
        if (w_m_ready && (r_rt_E == r_num_M)) begin
            Fwd_rt_E = 2'b01;
        end else if (w_w_ready && (r_rt_E == r_num_W)) begin
            Fwd_rt_E = 2'b10;
        end
    end

    //--------------------------------------------------------------------------
    // M-stage store data: only W is older than M
    //--------------------------------------------------------------------------
    assign Fwd_rt_M = (r_rt_M != 5'd0) && (r_rt_M == r_num_W);

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//==============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Directed scenarios from
//                the pipeline hazard cases plus randomized instruction streams
//                checked against a history-based reference model.
//  Revision    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr_D;
    logic [1:0]  Tnew_E;
    logic [4:0]  Num_new_E;
    logic        stall;
    logic [1:0]  Fwd_rs_D;
    logic [1:0]  Fwd_rt_D;
    logic [1:0]  Fwd_rs_E;
    logic [1:0]  Fwd_rt_E;
    logic        Fwd_rt_M;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .Instr_D   (Instr_D),
        .Tnew_E    (Tnew_E),
        .Num_new_E (Num_new_E),
        .stall     (stall),
        .Fwd_rs_D  (Fwd_rs_D),
        .Fwd_rt_D  (Fwd_rt_D),
        .Fwd_rs_E  (Fwd_rs_E),
        .Fwd_rt_E  (Fwd_rt_E),
        .Fwd_rt_M  (Fwd_rt_M)
    );

    always #5 clk = ~clk;

    //--------------------------------------------------------------------------
    // Instruction builders
    //--------------------------------------------------------------------------
    localparam logic [5:0] c_ADD = 6'b100000;
    localparam logic [5:0] c_SUB = 6'b100010;
    localparam logic [5:0] c_JR  = 6'b001000;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    //--------------------------------------------------------------------------
    // Reference model. History of what entered E in the last two cycles:
    // entry [0] is now in M, entry [1] is now in W.
    //--------------------------------------------------------------------------
    typedef struct packed { logic [4:0] num; logic [1:0] tnew; } wr_t;
    typedef struct packed { logic [4:0] rs;  logic [4:0] rt;   } src_t;

    wr_t  wq[$];
    src_t sq[$];

    function automatic void model_clear();
        wq = '{wr_t'(0), wr_t'(0)};
        sq = '{src_t'(0), src_t'(0)};
    endfunction

    // Cycle at which an operand is read, relative to D; 3 = never read.
    function automatic int tuse_of(input logic [31:0] ins, input bit is_rt);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'b000100) return 0;
        if (op == 6'b111111) return is_rt ? 3 : 0;
        if (op == 6'b000000 && fn == c_JR) return is_rt ? 3 : 0;
        if (op == 6'b000000 && (fn == c_ADD || fn == c_SUB)) return 1;
        if (op == 6'b001101 || op == 6'b100011) return is_rt ? 3 : 1;
        if (op == 6'b101011) return is_rt ? 2 : 1;
        return 3;
    endfunction

    // Cycles still needed by the producer now sitting in M.
    function automatic int m_wait();
        int t;
        t = int'(wq[0].tnew) - 1;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit exp_stall();
        logic [4:0] src;
        int         tu;
        for (int k = 0; k < 2; k++) begin
            src = (k == 0) ? Instr_D[25:21] : Instr_D[20:16];
            tu  = tuse_of(Instr_D, k == 1);
            if (src != 5'd0) begin
                if (src == Num_new_E && tu < int'(Tnew_E)) return 1'b1;
                if (src == wq[0].num && tu < m_wait())   return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] exp_fwd_d(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (src == Num_new_E && Tnew_E == 2'd0) return 2'b01;
        if (src == wq[0].num && m_wait() == 0) return 2'b10;
        if (src == wq[1].num) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (src == wq[0].num && m_wait() == 0) return 2'b01;
        if (src == wq[1].num) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic exp_fwd_m();
        return (sq[1].rt != 5'd0) && (sq[1].rt == wq[1].num);
    endfunction

    function automatic void model_advance();
        src_t s;
        if (reset) begin
            model_clear();
        end else begin
            s = exp_stall() ? src_t'(0) : {Instr_D[25:21], Instr_D[20:16]};
            wq.push_front({Num_new_E, Tnew_E});
            sq.push_front(s);
            void'(wq.pop_back());
            void'(sq.pop_back());
        end
    endfunction

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic set_in(input logic [31:0] ins, input logic [1:0] tn, input logic [4:0] num);
        Instr_D   = ins;
        Tnew_E    = tn;
        Num_new_E = num;
    endtask

    // Commit the current inputs at the next rising edge; resume 1ns after it.
    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        reset = 1'b0;
        set_in(32'h0, 2'd0, 5'd0);
        repeat (3) tick();
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset();
        logic [9:0] got;
        reset = 1'b1;
        set_in(rtype(5'd1, 5'd2, 5'd3, c_ADD), 2'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            got = {stall, Fwd_rs_D, Fwd_rt_D, Fwd_rs_E, Fwd_rt_E, Fwd_rt_M};
            n_checks++;
            if (got !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", i, got, 10'b0);
            end
            tick();
        end
    endtask

    task automatic test_lw_beq();
        logic [31:0] beq5;
        flush();
        beq5 = itype(6'b000100, 5'd5, 5'd0, 16'd4);
        set_in(beq5, 2'd2, 5'd5);
        #3;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_beq_stall_c0: got %b expected 1", stall);
        end
        tick();
        set_in(beq5, 2'd0, 5'd0);
        #3;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_beq_stall_c1: got %b expected 1", stall);
        end
        tick();
        #3;
        n_checks++;
        if ({stall, Fwd_rs_D} !== 3'b011) begin
            n_fail++;
            $display("FAIL lw_beq_release: got stall=%b Fwd_rs_D=%b expected stall=0 Fwd_rs_D=11",
                     stall, Fwd_rs_D);
        end
        tick();
    endtask

    task automatic test_ori_add();
        flush();
        set_in(rtype(5'd7, 5'd7, 5'd8, c_ADD), 2'd1, 5'd7);
        #3;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL ori_add_stall: got %b expected 0", stall);
        end
        tick();
        set_in(32'h0, 2'd1, 5'd8);
        #3;
        n_checks++;
        if ({Fwd_rs_E, Fwd_rt_E} !== 4'b0101) begin
            n_fail++;
            $display("FAIL ori_add_fwd_e: got rs=%b rt=%b expected rs=01 rt=01", Fwd_rs_E, Fwd_rt_E);
        end
        tick();
    endtask

    task automatic test_jal_jr();
        flush();
        set_in(rtype(5'd31, 5'd0, 5'd0, c_JR), 2'd0, 5'd31);
        #3;
        n_checks++;
        if ({stall, Fwd_rs_D} !== 3'b001) begin
            n_fail++;
            $display("FAIL jal_jr: got stall=%b Fwd_rs_D=%b expected stall=0 Fwd_rs_D=01",
                     stall, Fwd_rs_D);
        end
        tick();
    endtask

    task automatic test_lw_sw();
        flush();
        set_in(itype(6'b101011, 5'd9, 5'd4, 16'd0), 2'd2, 5'd4);
        #3;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_sw_stall: got %b expected 0", stall);
        end
        tick();
        set_in(32'h0, 2'd0, 5'd0);
        tick();
        #3;
        n_checks++;
        if (Fwd_rt_M !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_sw_fwd_m: got %b expected 1", Fwd_rt_M);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        logic [9:0] got;
        flush();
        set_in(rtype(5'd0, 5'd0, 5'd1, c_ADD), 2'd2, 5'd0);
        #3;
        got = {stall, Fwd_rs_D, Fwd_rt_D, Fwd_rs_E, Fwd_rt_E, Fwd_rt_M};
        n_checks++;
        if (got !== 10'b0) begin
            n_fail++;
            $display("FAIL zero_reg: got %b expected %b", got, 10'b0);
        end
        tick();
        // ori reads only rs; its rt field matching a pending load is harmless.
        flush();
        set_in(itype(6'b001101, 5'd1, 5'd5, 16'd3), 2'd2, 5'd5);
        #3;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL tuse_unused: got %b expected 0", stall);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] beq5;
        flush();
        beq5 = itype(6'b000100, 5'd5, 5'd0, 16'd4);
        set_in(beq5, 2'd2, 5'd5);
        tick();
        set_in(beq5, 2'd0, 5'd0);
        #3;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stall_before_reset: got %b expected 1", stall);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stall_after_reset: got %b expected 0", stall);
        end
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0:  return itype(6'b000100, rs, rt, 16'd8);
            1:  return rtype(rs, 5'd0, 5'd0, c_JR);
            2:  return itype(6'b111111, rs, rt, 16'd2);
            3:  return rtype(rs, rt, rd, c_ADD);
            4:  return rtype(rs, rt, rd, c_SUB);
            5:  return itype(6'b001101, rs, rt, 16'h00ff);
            6:  return itype(6'b100011, rs, rt, 16'd4);
            7:  return itype(6'b101011, rs, rt, 16'd8);
            8:  return itype(6'b001111, rs, rt, 16'h1234);
            9:  return itype(6'b000010, rs, rt, 16'd0);
            10: return itype(6'b000011, rs, rt, 16'd0);
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random();
        bit          prev_stall;
        logic [31:0] ins;
        logic        e_stall;
        logic [1:0]  e_rs_d;
        logic [1:0]  e_rt_d;
        logic [1:0]  e_rs_e;
        logic [1:0]  e_rt_e;
        logic        e_m;
        flush();
        prev_stall = 1'b0;
        ins        = 32'h0;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            if (prev_stall) begin
                set_in(ins, 2'd0, 5'd0);
            end else begin
                ins = rand_instr();
                set_in(ins, 2'($urandom_range(0, 2)), 5'($urandom_range(0, 3)));
            end
            #3;
            e_stall = exp_stall();
            e_rs_d  = exp_fwd_d(Instr_D[25:21]);
            e_rt_d  = exp_fwd_d(Instr_D[20:16]);
            e_rs_e  = exp_fwd_e(sq[0].rs);
            e_rt_e  = exp_fwd_e(sq[0].rt);
            e_m     = exp_fwd_m();
            n_checks++;
            if (stall !== e_stall) begin
                n_fail++;
                $display("FAIL rnd_stall cycle %0d: got %b expected %b", i, stall, e_stall);
            end
            n_checks++;
            if (Fwd_rs_D !== e_rs_d) begin
                n_fail++;
                $display("FAIL rnd_fwd_rs_d cycle %0d: got %b expected %b", i, Fwd_rs_D, e_rs_d);
            end
            n_checks++;
            if (Fwd_rt_D !== e_rt_d) begin
                n_fail++;
                $display("FAIL rnd_fwd_rt_d cycle %0d: got %b expected %b", i, Fwd_rt_D, e_rt_d);
            end
            n_checks++;
            if (Fwd_rs_E !== e_rs_e) begin
                n_fail++;
                $display("FAIL rnd_fwd_rs_e cycle %0d: got %b expected %b", i, Fwd_rs_E, e_rs_e);
            end
            n_checks++;
            if (Fwd_rt_E !== e_rt_e) begin
                n_fail++;
                $display("FAIL rnd_fwd_rt_e cycle %0d: got %b expected %b", i, Fwd_rt_E, e_rt_e);
            end
            n_checks++;
            if (Fwd_rt_M !== e_m) begin
                n_fail++;
                $display("FAIL rnd_fwd_rt_m cycle %0d: got %b expected %b", i, Fwd_rt_M, e_m);
            end
            prev_stall = e_stall && !reset;
            tick();
        end
        reset = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    // Sequencer
    //--------------------------------------------------------------------------
    initial begin
        model_clear();
        reset = 1'b1;
        set_in(32'h0, 2'd0, 5'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_lw_beq();
        test_ori_add();
        test_jal_jr();
        test_lw_sw();
        test_zero_reg();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
